// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the MIPS M-stage data access into a single-outstanding
// request/response bus transaction. It stalls the pipeline until the access
// completes and maps kseg0/kseg1 virtual addresses to physical addresses.
module dmem_bridge #(
    parameter bit KSEG_XLATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_cpu_rdata;
    logic [31:0] w_phys_addr;

    // kseg0 (0x8...) and kseg1 (0xA...) both live where bits [31:30] = 2'b10;
    // clearing [31:29] folds them onto the same low physical window.
    assign w_phys_addr = (KSEG_XLATE && (cpu_addr[31:30] == 2'b10))
                       ? {3'b000, cpu_addr[28:0]}
                       : cpu_addr;

    // Stall is combinational so the pipeline freezes in the very cycle the
    // access is presented; DONE releases it for exactly one cycle.
    assign cpu_stall = ((r_state == IDLE) && cpu_en)
                     || (r_state == ADDR)
                     || (r_state == DATA);

    // Request FSM: capture in IDLE, hold the request until accepted, then wait
    // for the response. Bus outputs only change on capture, so they stay stable
    // while the request waits for acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_wstrb <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_cpu_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_en) begin
                        r_bus_wr    <= |cpu_wen;
                        r_bus_wstrb <= cpu_wen;
                        r_bus_addr  <= w_phys_addr;
                        r_bus_wdata <= cpu_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    // A response without acceptance is meaningless and ignored.
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            if (!r_bus_wr) begin
                                r_cpu_rdata <= bus_rdata;
                            end
                            r_state <= DONE;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        if (!r_bus_wr) begin
                            r_cpu_rdata <= bus_rdata;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a held cpu_en cannot issue a
                    // duplicate request in the release cycle.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign cpu_rdata = r_cpu_rdata;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the pipelined MIPS datapath's memory stage.
- Converts the M-stage data access (byte write enables, ALU-computed address, aligned write data) into a single-outstanding request/response bus toward data SRAM or the AXI wrapper.
- Returns read data to the datapath and raises a stall to the hazard unit until the access completes.
- Also performs fixed kseg0/kseg1 virtual-to-physical address translation.

Parameters:
- KSEG_XLATE, 1, 1: addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared on bus_addr; 0: address passes through unchanged.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  M-stage access valid (load or store)
- cpu_wen  in  4  byte write enables; 0 = load
- cpu_addr  in  32  virtual byte address (aluoutM)
- cpu_wdata  in  32  byte-lane-aligned store data
- cpu_rdata  out  32  load data, valid in DONE
- cpu_stall  out  1  hold M stage and earlier stages
- bus_req  out  1  request valid
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  byte strobes
- bus_addr  out  32  physical address, low 2 bits passed through
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  response (read data / write ack) this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok

Behaviour:
- Clock/reset: one clock. rst is asynchronous, active-high.
- Reset values: state = IDLE; bus_req = 0; bus_wr = 0; bus_wstrb = 0; bus_addr = 0; bus_wdata = 0; cpu_rdata = 0. cpu_stall follows the combinational rule below.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cpu_en = 1: capture wr = |cpu_wen, wstrb, translated address and wdata into request registers, then go to ADDR.
  - cpu_en = 0: stay in IDLE.
- ADDR: bus_req = 1, all bus outputs held stable.
  - addr_ok & data_ok (same cycle): latch rdata, go to DONE.
  - addr_ok only: go to DATA.
  - Neither: stay in ADDR.
- DATA: bus_req = 0. data_ok: latch bus_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged), go to DONE.
- DONE: one cycle, stall = 0 so the pipeline advances past the access, then return to IDLE. A new cpu_en in this cycle is not accepted; it is picked up in IDLE on the next cycle.
- cpu_stall = (IDLE & cpu_en) | ADDR | DATA. It is combinational, so the first access cycle already stalls.
- Minimum access latency: IDLE → ADDR → DONE = 3 cycles with stall high for 2.
- data_ok received in IDLE, DONE or ADDR-without-addr_ok is ignored.
- Only one outstanding transaction at a time.
- Translation (KSEG_XLATE = 1): address bits [31:30] = 2'b10 → bits [31:29] cleared. All other addresses pass unchanged.
- Inputs are sampled only in IDLE; changes to cpu_* during ADDR/DATA have no effect.
- Reset asserted mid-transaction: immediate return to IDLE with bus_req = 0. Any later data_ok is ignored.

Test Plan:
- Load word: cpu_en = 1, wen = 0, addr = 0x8000_0010; addr_ok at cycle 1, data_ok = 1 with rdata = 0xDEADBEEF at cycle 3 → bus_addr = 0x0000_0010, bus_wr = 0, stall high cycles 0–3, DONE at cycle 4 with cpu_rdata = 0xDEADBEEF and stall = 0.
- Byte store: wen = 4'b0100, addr = 0xA000_0006, wdata = 0x00AB_0000, addr_ok and data_ok together → bus_wr = 1, wstrb = 0100, bus_addr = 0x0000_0006, DONE in cycle 2, cpu_rdata unchanged.
- Back-to-back: cpu_en held high across two accesses → second bus_req appears only after the DONE cycle passes through IDLE; no duplicate request.
- addr_ok delayed 5 cycles → bus_req, addr, wdata and wstrb stable throughout; stall continuously high.
- rst pulsed during DATA → bus_req = 0, state IDLE, stall = cpu_en; a stray data_ok after reset does not change cpu_rdata.
- KSEG_XLATE = 0, addr = 0xBFC0_0000 → bus_addr = 0xBFC0_0000. With default KSEG_XLATE, addr = 0x1FC0_0004 (kuseg) → passes unchanged.
